// File: rtl/fifo_pattern_reader_if.sv
// FIFO read-port bundle: empty flag and read data come from the FIFO,
// and the read strobe goes back to it.
interface fifo_pattern_reader_if #(
  parameter int DATA_W = 8
);
  logic              empty;
  logic [DATA_W-1:0] d_out;
  logic              rd_en;

  // Reader side: consumes empty/d_out and issues rd_en
  modport master (
    input  empty,
    input  d_out,
    output rd_en
  );

  // FIFO side: supplies empty/d_out and receives rd_en
  modport slave (
    output empty,
    output d_out,
    input  rd_en
  );
endinterface

// File: rtl/fifo_pattern_reader.sv
// Drains the camera FIFO and checks every word against the repeating
// P0, P1, P2 test pattern. It reports lock status, error and word counts,
// and an activity LED.
module fifo_pattern_reader #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] P0     = 8'h0A,
  parameter logic [DATA_W-1:0] P1     = 8'h0C,
  parameter logic [DATA_W-1:0] P2     = 8'h0E,
  parameter int                LOCK_N = 3,
  parameter int                ERR_W  = 8,
  parameter int                CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  fifo_pattern_reader_if.master fifo,
  output logic                  locked,
  output logic [ERR_W-1:0]      err_count,
  output logic [CNT_W-1:0]      word_count,
  output logic                  leden
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [3*DATA_W-1:0] PATS  = {P2, P1, P0};
  localparam logic [3:0]          LOCK4 = 4'(LOCK_N);

  state_t           state_reg;
  logic             rd_vld_reg;
  logic [1:0]       idx_reg;
  logic [3:0]       run_reg;
  logic             locked_reg;
  logic [ERR_W-1:0] err_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             leden_reg;

  // hit[i] flags that the sampled word equals pattern word i.
  // Entry 3 is never a valid index, so it never matches.
  logic [3:0] hit;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hit
      assign hit[gi] = (fifo.d_out == PATS[gi*DATA_W +: DATA_W]);
    end
  endgenerate
  assign hit[3] = 1'b0;

  logic [1:0]       hunt_idx_next;
  logic [1:0]       trk_idx_next;
  logic [3:0]       run_next;
  logic [ERR_W-1:0] err_next;
  logic [CNT_W-1:0] cnt_next;

  // Successor indices, saturating increments and run-length update
  always_comb begin
    hunt_idx_next = 2'd0;
    if (hit[0]) begin
      hunt_idx_next = 2'd1;
    end else if (hit[1]) begin
      hunt_idx_next = 2'd2;
    end
    trk_idx_next = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
    run_next     = (run_reg >= LOCK4) ? run_reg : run_reg + 4'd1;
    err_next     = (&err_reg) ? err_reg : err_reg + 1'b1;
    cnt_next     = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  end

  // Reads go out whenever running and data is available; reset blocks them
  assign fifo.rd_en = enable & ~fifo.empty & ~reset;

  // Track the pattern on words whose read was accepted one cycle earlier
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= HUNT;
      rd_vld_reg <= 1'b0;
      idx_reg    <= 2'd0;
      run_reg    <= 4'd0;
      locked_reg <= 1'b0;
      err_reg    <= '0;
      cnt_reg    <= '0;
      leden_reg  <= 1'b0;
    end else begin
      rd_vld_reg <= fifo.rd_en;
      if (rd_vld_reg) begin
        cnt_reg   <= cnt_next;
        leden_reg <= 1'b1;
        case (state_reg)
          HUNT: begin
            if (|hit[2:0]) begin
              idx_reg    <= hunt_idx_next;
              run_reg    <= 4'd1;
              locked_reg <= (LOCK4 == 4'd1);
              state_reg  <= TRACK;
            end else begin
              err_reg <= err_next;
            end
          end
          TRACK: begin
            if (hit[idx_reg]) begin
              idx_reg <= trk_idx_next;
              run_reg <= run_next;
              if (run_next == LOCK4) begin
                locked_reg <= 1'b1;
              end
            end else begin
              // The offending word is not reused for resync
              err_reg    <= err_next;
              locked_reg <= 1'b0;
              run_reg    <= 4'd0;
              state_reg  <= HUNT;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign locked     = locked_reg;
  assign err_count  = err_reg;
  assign word_count = cnt_reg;
  assign leden      = leden_reg;

endmodule

// File: tb/tb_fifo_pattern_reader.sv
// Directed bench for fifo_pattern_reader. A small queue plays the FIFO:
// it pops one word per accepted read and presents it on d_out a cycle later.
module tb_fifo_pattern_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        locked;
  logic        leden;
  logic [7:0]  err_count;
  logic [15:0] word_count;

  fifo_pattern_reader_if #(.DATA_W(8)) fifo_if ();

  fifo_pattern_reader dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo       (fifo_if),
    .locked     (locked),
    .err_count  (err_count),
    .word_count (word_count),
    .leden      (leden)
  );

  always #5 clock = ~clock;

  logic [7:0] q[$];
  logic       gate;
  logic       last_rd;
  int         rd_pulses;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: set empty, note whether a read was issued, then
  // present the popped word just after the edge.
  task automatic cycle();
    fifo_if.empty = gate || (q.size() == 0);
    #1;
    last_rd = fifo_if.rd_en;
    if (last_rd) rd_pulses++;
    @(posedge clock);
    #1;
    if (last_rd && q.size() > 0) fifo_if.d_out = q.pop_front();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    gate   = 1'b0;
    q.delete();
    cycle();
    check("rst_rd_en", 32'(last_rd), 32'd0);
    reset = 1'b0;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_words", 32'(word_count), 32'd0);
    check("rst_leden", 32'(leden), 32'd0);
    rd_pulses = 0;
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    gate          = 1'b0;
    rd_pulses     = 0;
    last_rd       = 1'b0;
    fifo_if.empty = 1'b1;
    fifo_if.d_out = 8'h00;

    // Test 1: clean preloaded stream
    do_reset();
    q = '{8'h0A, 8'h0C, 8'h0E, 8'h0A, 8'h0C, 8'h0E};
    enable = 1'b1;
    run(1);
    check("t1_leden_early", 32'(leden), 32'd0);
    run(1);
    check("t1_leden", 32'(leden), 32'd1);
    run(1);
    check("t1_unlocked_c3", 32'(locked), 32'd0);
    run(1);
    check("t1_locked_c4", 32'(locked), 32'd1);
    check("t1_words_c4", 32'(word_count), 32'd3);
    run(4);
    check("t1_rd_pulses", 32'(rd_pulses), 32'd6);
    check("t1_words", 32'(word_count), 32'd6);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_locked", 32'(locked), 32'd1);

    // Test 2: stream starting mid-sequence
    do_reset();
    q = '{8'h0E, 8'h0A, 8'h0C, 8'h0E};
    enable = 1'b1;
    run(3);
    check("t2_unlocked", 32'(locked), 32'd0);
    run(1);
    check("t2_locked", 32'(locked), 32'd1);
    run(2);
    check("t2_words", 32'(word_count), 32'd4);
    check("t2_err", 32'(err_count), 32'd0);

    // Test 3: corrupted word then resync
    do_reset();
    q = '{8'h0A, 8'h0C, 8'h55, 8'h0E, 8'h0A, 8'h0C};
    enable = 1'b1;
    run(4);
    check("t3_err_hit", 32'(err_count), 32'd1);
    check("t3_unlocked", 32'(locked), 32'd0);
    run(2);
    check("t3_relock_pending", 32'(locked), 32'd0);
    run(1);
    check("t3_relocked", 32'(locked), 32'd1);
    run(2);
    check("t3_words", 32'(word_count), 32'd6);
    check("t3_err", 32'(err_count), 32'd1);

    // Test 4: empty gaps, simultaneous empty fall / enable rise, enable drop
    do_reset();
    q = '{8'h0A, 8'h0C, 8'h0E};
    gate = 1'b1;
    cycle();
    check("t4_no_rd_idle", 32'(last_rd), 32'd0);
    enable = 1'b1;
    gate   = 1'b0;
    cycle();
    check("t4_rd_same_cycle", 32'(last_rd), 32'd1);
    for (int i = 1; i < 8; i++) begin
      gate = (i % 2 == 1);
      cycle();
      if (gate) check("t4_rd_gap", 32'(last_rd), 32'd0);
    end
    gate = 1'b0;
    check("t4_rd_pulses", 32'(rd_pulses), 32'd3);
    check("t4_words", 32'(word_count), 32'd3);
    check("t4_err", 32'(err_count), 32'd0);
    check("t4_locked", 32'(locked), 32'd1);
    q.push_back(8'h0A);
    q.push_back(8'h0C);
    cycle();
    enable = 1'b0;
    run(3);
    check("t4_drop_rd_pulses", 32'(rd_pulses), 32'd4);
    check("t4_drop_words", 32'(word_count), 32'd4);
    check("t4_drop_left", 32'(q.size()), 32'd1);
    check("t4_drop_locked", 32'(locked), 32'd1);
    enable = 1'b1;
    run(3);
    check("t4_resume_words", 32'(word_count), 32'd5);
    check("t4_resume_err", 32'(err_count), 32'd0);
    check("t4_resume_locked", 32'(locked), 32'd1);

    // Test 5: error counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) q.push_back(8'hFF);
    enable = 1'b1;
    run(201);
    check("t5_err_200", 32'(err_count), 32'd200);
    run(104);
    check("t5_err_sat", 32'(err_count), 32'd255);
    check("t5_words", 32'(word_count), 32'd300);
    check("t5_locked", 32'(locked), 32'd0);
    check("t5_rd_pulses", 32'(rd_pulses), 32'd300);

    // Test 6: reset while locked with a word in flight, then relock
    do_reset();
    q = '{8'h0A, 8'h0C, 8'h0E, 8'h0A, 8'h0C, 8'h0E, 8'h0A};
    enable = 1'b1;
    run(5);
    check("t6_pre_locked", 32'(locked), 32'd1);
    check("t6_pre_words", 32'(word_count), 32'd4);
    reset = 1'b1;
    cycle();
    check("t6_rst_rd_en", 32'(last_rd), 32'd0);
    reset = 1'b0;
    check("t6_rst_locked", 32'(locked), 32'd0);
    check("t6_rst_words", 32'(word_count), 32'd0);
    check("t6_rst_err", 32'(err_count), 32'd0);
    check("t6_rst_leden", 32'(leden), 32'd0);
    q = '{8'h0A, 8'h0C, 8'h0E};
    run(5);
    check("t6_words", 32'(word_count), 32'd3);
    check("t6_locked", 32'(locked), 32'd1);
    check("t6_err", 32'(err_count), 32'd0);
    check("t6_leden", 32'(leden), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_pattern_reader.md
Name: fifo_pattern_reader

Overview:
- Read-side counterpart of the camera FIFO test-pattern source, which writes the repeating byte sequence 8'h0A, 8'h0C, 8'h0E.
- Drains the FIFO through its read port and checks every word against that sequence.
- Reports lock status, error count and word count to LEDs and debug pins.
- Sits between the FIFO read port and the board LED/debug outputs on the FPGA bring-up build.

Parameters:
DATA_W, 8, FIFO data width
P0, 8'h0A, first pattern word
P1, 8'h0C, second pattern word
P2, 8'h0E, third pattern word
LOCK_N, 3, consecutive correct words needed to assert locked (1..15)
ERR_W, 8, error counter width
CNT_W, 16, word counter width

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  run request; reads are issued only while high
empty  input  1  FIFO empty flag
d_out  input  DATA_W  FIFO read data, valid the cycle after an accepted rd_en
rd_en  output  1  FIFO read strobe
locked  output  1  pattern tracked for at least LOCK_N consecutive words
err_count  output  ERR_W  mismatches since reset, saturating
word_count  output  CNT_W  words received since reset, saturating
leden  output  1  activity LED: high once any word has been received since reset

Behaviour:
- rd_en is combinational: rd_en = enable & ~empty & ~reset. A read is accepted in any cycle where rd_en=1.
- Internal rd_vld register captures the accepted read (rd_vld <= rd_en). d_out is sampled on the edge ending the cycle where rd_vld=1.
- Read-to-check latency is 1 cycle. Counter and flag updates become visible 2 cycles after the rd_en cycle.
- Reset (synchronous, wins over everything):
  - rd_en=0, locked=0, err_count=0, word_count=0, leden=0.
  - state=HUNT, rd_vld=0, expected index=0, match run=0.
  - A word in flight at reset is discarded.
- On every sampled word: word_count += 1, saturating at all-ones; leden <= 1 and stays 1 until reset.
- FSM, 2 states:
  - HUNT: sampled word equal to P0, P1 or P2 sets the expected index to the successor (P0->P1, P1->P2, P2->P0), sets run=1 and goes to TRACK. Any other value: err_count += 1, stay in HUNT.
  - TRACK, word equals expected: advance the index with wrap P2->P0, run += 1 saturating at LOCK_N. locked <= 1 when run reaches LOCK_N.
  - TRACK, word differs: err_count += 1, locked <= 0, run=0, next state HUNT. The mismatching word is not re-evaluated for resync.
  - With LOCK_N=1, locked asserts on the first matching word accepted in HUNT.
- err_count and word_count saturate and never wrap.
- enable low: no new reads. A word from a read accepted the previous cycle is still checked. State, counters and locked hold. Re-enabling resumes with the same expected index.
- empty high: no read and no check that cycle. Gaps are not errors.
- Simultaneous empty falling and enable rising: a read is issued that same cycle.
- Duplicate words are errors (e.g. 0A,0A breaks the sequence).

Test Plan:
- Reset, then FIFO preloaded 0A,0C,0E,0A,0C,0E with enable=1 -> 6 rd_en pulses, word_count=6, err_count=0, locked=1 two cycles after the 3rd read, leden=1.
- Stream starting mid-sequence 0E,0A,0C,0E -> HUNT accepts 0E, locked after the 3rd word, err_count=0.
- Stream 0A,0C,55,0E,0A,0C -> 55 gives err_count=1 and locked=0. Resync on 0E, locked again after 0C, final err_count=1, word_count=6.
- Empty toggling every other cycle with sequence 0A,0C,0E -> rd_en only while empty=0, no errors, word_count=3. Enable dropped the cycle after a read -> that word is still counted and no further reads occur.
- 300 consecutive bad words (8'hFF) with ERR_W=8 -> err_count saturates at 255, locked=0.
- Assert reset while locked with a read in flight -> all outputs 0 next cycle, in-flight word not counted. Subsequent 0A,0C,0E -> relock.
